board_batch_spi_master: RTL and testbench

//  SPI master that plays the Raspberry Pi's role toward the FPGA evaluator: serialises one batch
//  (mode byte, batch-size byte, 7x88-bit board slots) onto the link, then clocks back the 32-bit

---
 rtl/board_batch_spi_master.sv | 214 +++++++++++++++++++++
 tb/tb_board_batch_spi_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_batch_spi_master.sv
// board_batch_spi_master
//   SPI master (mode 0, active-high cs) that stands in for the host toward the
//   FPGA evaluator. It sends one batch frame {mode, batch_size, batch}, MSB
//   first. It then waits for the slave to compute and clocks back a 32-bit
//   signed evaluation.
// Ports
//   clk, reset       system clock, asynchronous active-low reset
//   start            1-cycle request, only looked at while idle
//   is_max_or_min    mode byte, latched on an accepted start
//   batch_size       number of valid boards, legal 1..MAX_BOARDS, latched on start
//   batch            88-bit board slots, slot i = batch[88*i +: 88], latched on start
//   busy             accepted start .. the DONE cycle
//   master_clk/cs/d_out/d_in   SPI link (sclk, chip select, MOSI, MISO)
//   evaluation       last received result, held between transfers
//   evaluation_valid 1-cycle pulse when evaluation updates
//   error            1-cycle pulse when a start carries an illegal batch_size
module board_batch_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int RESP_WAIT  = 512,
    parameter int MAX_BOARDS = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                is_max_or_min,
    input  logic [7:0]                batch_size,
    input  logic [88*MAX_BOARDS-1:0]  batch,
    output logic                      busy,
    output logic                      master_clk,
    output logic                      cs,
    output logic                      d_out,
    input  logic                      d_in,
    output logic signed [31:0]        evaluation,
    output logic                      evaluation_valid,
    output logic                      error
);

    localparam int BATCH_W  = 88 * MAX_BOARDS;
    localparam int FRAME_W  = BATCH_W + 16;
    localparam int TXC_W    = $clog2(FRAME_W);
    localparam int WAIT_MAX = (RESP_WAIT > CS_SETUP) ? RESP_WAIT : CS_SETUP;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);
    localparam int DIV_W    = $clog2(CLK_DIV + 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SETUP_TX = 4'd1;
    localparam logic [3:0] S_SHIFT_TX = 4'd2;
    localparam logic [3:0] S_HOLD_TX  = 4'd3;
    localparam logic [3:0] S_GAP      = 4'd4;
    localparam logic [3:0] S_SETUP_RX = 4'd5;
    localparam logic [3:0] S_SHIFT_RX = 4'd6;
    localparam logic [3:0] S_HOLD_RX  = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    typedef struct packed {
        logic [7:0]         mode;
        logic [7:0]         size;
        logic [BATCH_W-1:0] boards;
    } frame_t;

    frame_t             req;
    logic [3:0]         state;
    logic [FRAME_W-1:0] tx_sr;
    logic [TXC_W-1:0]   tx_cnt;
    logic [5:0]         rx_cnt;
    logic [31:0]        rx_sr;
    logic [CNT_W-1:0]   cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic               size_ok;
    logic               setup_done;
    logic               div_tick;

    always_comb begin
        req.mode   = is_max_or_min;
        req.size   = batch_size;
        req.boards = batch;
    end

    assign size_ok    = (batch_size != 8'd0) && (batch_size <= 8'(MAX_BOARDS));
    assign setup_done = (cnt == CNT_W'(CS_SETUP - 1));
    assign div_tick   = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            tx_sr            <= '0;
            tx_cnt           <= '0;
            rx_cnt           <= '0;
            rx_sr            <= '0;
            cnt              <= '0;
            div_cnt          <= '0;
            busy             <= 1'b0;
            master_clk       <= 1'b0;
            cs               <= 1'b0;
            d_out            <= 1'b0;
            evaluation       <= '0;
            evaluation_valid <= 1'b0;
            error            <= 1'b0;
        end else begin
            evaluation_valid <= 1'b0;
            error            <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (size_ok) begin
                            // The shift register is the latched copy of the request, so
                            // later input changes cannot reach the frame in flight.
                            tx_sr  <= req;
                            d_out  <= req.mode[7];
                            tx_cnt <= '0;
                            rx_cnt <= '0;
                            cnt    <= '0;
                            cs     <= 1'b1;
                            busy   <= 1'b1;
                            state  <= S_SETUP_TX;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                S_SETUP_TX, S_SETUP_RX: begin
                    if (setup_done) begin
                        cnt        <= '0;
                        div_cnt    <= '0;
                        master_clk <= 1'b1;
                        // First RX rise samples MISO on the same edge that raises sclk.
                        if (state == S_SETUP_RX) rx_sr <= {rx_sr[30:0], d_in};
                        state <= (state == S_SETUP_TX) ? S_SHIFT_TX : S_SHIFT_RX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT_TX: begin
                    if (div_tick) begin
                        div_cnt <= '0;
                        if (!master_clk) begin
                            master_clk <= 1'b1;
                        end else begin
                            master_clk <= 1'b0;
                            if (tx_cnt == TXC_W'(FRAME_W - 1)) begin
                                cnt   <= '0;
                                state <= S_HOLD_TX;
                            end else begin
                                // Next bit goes out on the fall, stable for the slave's rise.
                                tx_cnt <= tx_cnt + 1'b1;
                                tx_sr  <= {tx_sr[FRAME_W-2:0], 1'b0};
                                d_out  <= tx_sr[FRAME_W-2];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_HOLD_TX: begin
                    if (setup_done) begin
                        cnt   <= '0;
                        cs    <= 1'b0;
                        d_out <= 1'b0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    // Slave compute time; cs low and sclk idle throughout.
                    if (cnt == CNT_W'(RESP_WAIT - 1)) begin
                        cnt   <= '0;
                        cs    <= 1'b1;
                        state <= S_SETUP_RX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT_RX: begin
                    if (div_tick) begin
                        div_cnt <= '0;
                        if (!master_clk) begin
                            master_clk <= 1'b1;
                            rx_sr      <= {rx_sr[30:0], d_in};
                        end else begin
                            master_clk <= 1'b0;
                            if (rx_cnt == 6'd31) begin
                                cnt   <= '0;
                                state <= S_HOLD_RX;
                            end else begin
                                rx_cnt <= rx_cnt + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_HOLD_RX: begin
                    if (setup_done) begin
                        cnt              <= '0;
                        cs               <= 1'b0;
                        evaluation       <= rx_sr;
                        evaluation_valid <= 1'b1;
                        state            <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_batch_spi_master.sv
// Bench for board_batch_spi_master: a behavioural SPI slave captures the TX
// frame and returns a queued response. Expected frames and evaluations are
// queued at stimulus time and checked by independent monitor processes.
module tb_board_batch_spi_master;

    localparam int CLK_DIV   = 4;
    localparam int CS_SETUP  = 2;
    localparam int RESP_WAIT = 40;
    localparam int BW        = 88 * 7;
    localparam int FW        = BW + 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        is_max_or_min;
    logic [7:0]        batch_size;
    logic [BW-1:0]     batch;
    logic              busy, master_clk, cs, d_out;
    logic              d_in;
    logic signed [31:0] evaluation;
    logic              evaluation_valid, error;

    board_batch_spi_master #(
        .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .RESP_WAIT(RESP_WAIT), .MAX_BOARDS(7)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .is_max_or_min(is_max_or_min),
        .batch_size(batch_size), .batch(batch), .busy(busy), .master_clk(master_clk),
        .cs(cs), .d_out(d_out), .d_in(d_in), .evaluation(evaluation),
        .evaluation_valid(evaluation_valid), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_valid  = 0;
    int exp_err  = 0;

    logic [FW-1:0] exp_frame_q[$];
    logic [31:0]   resp_q[$];
    logic [31:0]   exp_eval_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural slave (sampled on negedge) ----------------
    logic          prev_cs, prev_mclk, phase_rx, first_rise;
    logic [FW-1:0] rx_frame;
    logic [FW-1:0] exp_frame;
    logic [31:0]   cur_resp;
    int            nbits, ridx, cyc_cs, cyc_edge, gap;

    always @(negedge clk) begin
        if (!reset) begin
            prev_cs = 0; prev_mclk = 0; phase_rx = 0; first_rise = 0;
            nbits = 0; ridx = 0; cyc_cs = 0; cyc_edge = 0; gap = 0;
            rx_frame = '0; cur_resp = '0; d_in = 1'b0;
        end else begin
            cyc_cs++; cyc_edge++; gap++;
            if (cs && !prev_cs) begin
                if (phase_rx) begin
                    check("gap_len", gap, RESP_WAIT);
                    check("resp_available", resp_q.size() > 0, 1);
                    if (resp_q.size() > 0) cur_resp = resp_q.pop_front();
                    ridx = 31;
                    d_in = cur_resp[31];
                end
                cyc_cs = 0; nbits = 0; first_rise = 1;
            end
            if (master_clk != prev_mclk) begin
                check("mclk_inside_cs", cs, 1);
                if (master_clk) begin
                    if (first_rise) check("cs_setup", cyc_cs, CS_SETUP);
                    else            check("half_period_lo", cyc_edge, CLK_DIV);
                    first_rise = 0;
                    if (!phase_rx) rx_frame = {rx_frame[FW-2:0], d_out};
                    nbits++;
                end else begin
                    check("half_period_hi", cyc_edge, CLK_DIV);
                    if (phase_rx) begin
                        ridx--;
                        d_in = (ridx >= 0) ? cur_resp[ridx] : 1'b0;
                    end
                end
                cyc_edge = 0;
            end
            if (!cs && prev_cs) begin
                check("cs_hold", cyc_edge, CS_SETUP);
                if (!phase_rx) begin
                    check("tx_bits", nbits, FW);
                    check("frame_pending", exp_frame_q.size() > 0, 1);
                    if (exp_frame_q.size() > 0) begin
                        exp_frame = exp_frame_q.pop_front();
                        n_checks++;
                        if (rx_frame !== exp_frame) begin
                            n_err++;
                            $display("FAIL tx_frame: got %h expected %h", rx_frame, exp_frame);
                        end
                    end
                end else begin
                    check("rx_bits", nbits, 32);
                end
                phase_rx = !phase_rx;
                gap = 0;
            end
            prev_cs = cs; prev_mclk = master_clk;
        end
    end

    // ---------------- output monitor ----------------
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            if (evaluation_valid) begin
                check("valid_busy", busy, 1);
                check("valid_single", prev_valid, 0);
                check("eval_pending", exp_eval_q.size() > 0, 1);
                if (exp_eval_q.size() > 0) check("evaluation", evaluation, exp_eval_q.pop_front());
                n_valid++;
            end
            if (prev_valid) check("busy_after_done", busy, 0);
            if (error) begin
                check("error_expected", exp_err > 0, 1);
                if (exp_err > 0) exp_err--;
            end
        end
        prev_valid = evaluation_valid;
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [7:0] m, input logic [7:0] s, input logic [BW-1:0] b);
        @(negedge clk);
        is_max_or_min = m; batch_size = s; batch = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic launch(input logic [7:0] m, input logic [7:0] s, input logic [BW-1:0] b,
                          input logic [31:0] resp, input logic [31:0] exp_ev);
        exp_frame_q.push_back({m, s, b});
        resp_q.push_back(resp);
        exp_eval_q.push_back(exp_ev);
        do_start(m, s, b);
        // Scramble inputs after the start was taken; frame must not change.
        is_max_or_min = ~m; batch_size = 8'd3; batch = ~b;
    endtask

    task automatic wait_valid(input int target);
        int k;
        k = 0;
        while (n_valid < target && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("valid_timeout", n_valid >= target, 1);
    endtask

    task automatic wait_tx_bits(input int nb);
        int k;
        k = 0;
        while (!(cs && !phase_rx && nbits >= nb) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("tx_progress_timeout", k < 20000, 1);
    endtask

    logic [BW-1:0] b1, b2, b3, b7;

    initial begin
        reset = 1'b0; start = 1'b0; is_max_or_min = '0; batch_size = '0; batch = '0;
        b1 = '0;
        b1[87:0] = 88'hA5_11_0123_4567_89AB_CDEF_5A;
        b2 = '0;
        b2[87:0]   = 88'h00_FFEE_DDCC_BBAA_9988_7766;
        b2[175:88] = 88'h80_0000_0000_0000_0000_0001;
        b3 = '0;
        for (int i = 0; i < 3; i++) b3[88*i +: 88] = {8'hC0 + 8'(i), 80'h1357_9BDF_2468_ACE0_F00D};
        for (int i = 0; i < 7; i++) b7[88*i +: 88] = {8'(i + 1), 80'hDEAD_BEEF_0BAD_F00D_5555};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_mclk", master_clk, 0);
        check("rst_cs", cs, 0);
        check("rst_dout", d_out, 0);
        check("rst_busy", busy, 0);
        check("rst_eval", evaluation, 0);
        check("rst_valid", evaluation_valid, 0);
        check("rst_error", error, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // basic single-board batch
        launch(8'h01, 8'h01, b1, 32'h8000_0001, -32'sd2147483647);
        wait_valid(1);

        // reset while idle clears the held evaluation
        repeat (5) @(negedge clk);
        check("eval_held", evaluation, 32'h8000_0001);
        reset = 1'b0;
        #1;
        check("idle_rst_eval", evaluation, 0);
        check("idle_rst_cs", cs, 0);
        check("idle_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // illegal sizes 0 and 8
        exp_err = 1;
        do_start(8'h01, 8'd0, b1);
        repeat (3) begin
            @(negedge clk);
            check("bad0_cs", cs, 0);
            check("bad0_busy", busy, 0);
        end
        check("bad0_error_seen", exp_err, 0);
        exp_err = 1;
        do_start(8'h01, 8'd8, b1);
        repeat (3) begin
            @(negedge clk);
            check("bad8_cs", cs, 0);
            check("bad8_busy", busy, 0);
        end
        check("bad8_error_seen", exp_err, 0);

        // start while busy is ignored, even with an illegal size
        launch(8'h00, 8'd2, b2, 32'h0000_1234, 32'd4660);
        wait_tx_bits(100);
        do_start(8'hFF, 8'd5, ~b2);
        do_start(8'h00, 8'd0, b2);
        wait_valid(2);
        repeat (10) @(negedge clk);
        check("eval_hold2", evaluation, 32'd4660);

        // reset at TX bit 300
        launch(8'h01, 8'd3, b3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        wait_tx_bits(300);
        reset = 1'b0;
        #1;
        check("midrst_cs", cs, 0);
        check("midrst_mclk", master_clk, 0);
        check("midrst_busy", busy, 0);
        exp_frame_q.delete(); resp_q.delete(); exp_eval_q.delete();
        repeat (3) @(negedge clk);
        check("midrst_eval", evaluation, 0);
        check("midrst_valid", evaluation_valid, 0);
        reset = 1'b1;
        launch(8'h01, 8'd3, b3, 32'h7FFF_FFFF, 32'sd2147483647);
        wait_valid(3);

        // full 7-board batch, min mode
        launch(8'h00, 8'd7, b7, 32'hFFFF_FF85, -32'sd123);
        wait_valid(4);
        repeat (10) @(negedge clk);
        check("final_busy", busy, 0);
        check("frames_drained", exp_frame_q.size(), 0);
        check("evals_drained", exp_eval_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
